// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multi-cycle MIPS datapath with phase FSM and one shared stallable memory port
//
// Ports:
//   clk_i, rst_i                    clock (rising edge), asynchronous active-high reset
//   mem_req_o/we_o/addr_o/wdata_o   shared instruction/data request, held until mem_ready_i
//   mem_rdata_i, mem_ready_i        read data and transfer-complete strobe
//   mem_to_reg_i .. reg_write_i     control from the external decoder, driven from instr_o
//   instr_o, pc_o, state_o          IR, PC of the instruction in flight, FSM state
//   retire_o, retired_cnt_o         retire pulse and wrapping retired-instruction count
//   err_o                           sticky error (reserved jump or stall timeout)
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned STALL_LIMIT = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i,
    input  logic             mem_ready_i,
    input  logic             mem_to_reg_i,
    input  logic             mem_write_i,
    input  logic             branch_i,
    input  logic             branch_ne_i,
    input  logic [2:0]       jump_i,
    input  logic [3:0]       alu_control_i,
    input  logic [1:0]       alu_src_i,
    input  logic             reg_dst_i,
    input  logic             reg_write_i,
    output logic [31:0]      instr_o,
    output logic [31:0]      pc_o,
    output logic [2:0]       state_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] retired_cnt_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [31:0] STALL_LAST = 32'(STALL_LIMIT - 1);

    state_t      state_q;
    logic [31:0] rf [32];
    logic [31:0] a_q, b_q, alu_out_q, mdr_q, pc_plus4_q;
    logic [31:0] wait_cnt_q;

    logic [31:0] sign_imm, src_a, src_b, alu_y;
    logic [31:0] branch_target, jump_target, wb_data, fetch_pc;
    logic [4:0]  wb_dest;
    logic        zero, br_taken, fetch_go, stall_expire, is_load;

    assign state_o       = state_q;
    assign sign_imm      = {{16{instr_o[15]}}, instr_o[15:0]};
    assign src_a         = alu_src_i[1] ? {27'd0, instr_o[10:6]} : a_q;
    assign src_b         = alu_src_i[0] ? sign_imm : b_q;
    assign zero          = (alu_y == 32'd0);
    assign br_taken      = branch_i & (zero ^ branch_ne_i);
    assign branch_target = pc_plus4_q + (sign_imm << 2);
    assign jump_target   = {pc_plus4_q[31:28], instr_o[25:0], 2'b00};
    // A store wins when both memory controls are set, so only a pure load writes back MDR.
    assign is_load       = mem_to_reg_i & ~mem_write_i;
    assign wb_dest       = reg_dst_i ? instr_o[15:11] : instr_o[20:16];
    assign wb_data       = is_load ? mdr_q : alu_out_q;
    // req is only ever high in FETCH or MEMORY, so this covers both wait points.
    assign stall_expire  = (STALL_LIMIT != 0) && mem_req_o && !mem_ready_i &&
                           (wait_cnt_q == STALL_LAST);

    always_comb begin
        alu_y = 32'd0;
        case (alu_control_i)
            ALU_AND: alu_y = src_a & src_b;
            ALU_OR:  alu_y = src_a | src_b;
            ALU_ADD: alu_y = src_a + src_b;
            ALU_XOR: alu_y = src_a ^ src_b;
            ALU_SLL: alu_y = src_b << src_a[4:0];
            ALU_SRL: alu_y = src_b >> src_a[4:0];
            ALU_SUB: alu_y = src_a - src_b;
            ALU_SLT: alu_y = {31'd0, $signed(src_a) < $signed(src_b)};
            ALU_SRA: alu_y = 32'($signed(src_b) >>> src_a[4:0]);
            ALU_NOR: alu_y = ~(src_a | src_b);
            default: alu_y = 32'd0;
        endcase
    end

    // Every path that completes an instruction funnels through fetch_go so the
    // retire pulse, counter bump and next fetch launch happen on the same edge.
    always_comb begin
        fetch_go = 1'b0;
        fetch_pc = pc_plus4_q;
        case (state_q)
            S_EXECUTE: begin
                if (branch_i) begin
                    fetch_go = 1'b1;
                    if (br_taken) fetch_pc = branch_target;
                end else if (jump_i[1:0] == 2'b01) begin
                    fetch_go = 1'b1;
                    fetch_pc = jump_target;
                end else if (jump_i[1:0] == 2'b10) begin
                    fetch_go = 1'b1;
                    fetch_pc = a_q;
                end
            end
            S_MEMORY:    fetch_go = mem_ready_i & mem_write_i;
            S_WRITEBACK: fetch_go = 1'b1;
            default:     fetch_go = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_FETCH;
            pc_o          <= RESET_PC;
            pc_plus4_q    <= 32'd0;
            instr_o       <= 32'd0;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            alu_out_q     <= 32'd0;
            mdr_q         <= 32'd0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= 32'd0;
            mem_wdata_o   <= 32'd0;
            retire_o      <= 1'b0;
            retired_cnt_o <= '0;
            err_o         <= 1'b0;
            wait_cnt_q    <= 32'd0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else begin
            retire_o <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (!mem_req_o) begin
                        // Only reachable right after reset: launch the first fetch.
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= pc_o;
                        wait_cnt_q <= 32'd0;
                    end else if (mem_ready_i) begin
                        instr_o    <= mem_rdata_i;
                        pc_plus4_q <= pc_o + 32'd4;
                        mem_req_o  <= 1'b0;
                        state_q    <= S_DECODE;
                    end else if (stall_expire) begin
                        err_o     <= 1'b1;
                        mem_req_o <= 1'b0;
                        state_q   <= S_HALT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
                end
                S_DECODE: begin
                    a_q     <= rf[instr_o[25:21]];
                    b_q     <= rf[instr_o[20:16]];
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    alu_out_q <= alu_y;
                    if (jump_i[1:0] == 2'b11) err_o <= 1'b1;
                    if (jump_i[2]) rf[31] <= pc_plus4_q;
                    if (!fetch_go) begin
                        if (mem_write_i || mem_to_reg_i) begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= mem_write_i;
                            mem_addr_o  <= alu_y;
                            mem_wdata_o <= b_q;
                            wait_cnt_q  <= 32'd0;
                            state_q     <= S_MEMORY;
                        end else begin
                            state_q <= S_WRITEBACK;
                        end
                    end
                end
                S_MEMORY: begin
                    if (mem_ready_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        if (!mem_write_i) begin
                            mdr_q   <= mem_rdata_i;
                            state_q <= S_WRITEBACK;
                        end
                    end else if (stall_expire) begin
                        err_o     <= 1'b1;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        state_q   <= S_HALT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
                end
                S_WRITEBACK: begin
                    if (reg_write_i && (wb_dest != 5'd0)) rf[wb_dest] <= wb_data;
                end
                S_HALT: begin
                end
                default: state_q <= S_HALT;
            endcase

            if (fetch_go) begin
                state_q       <= S_FETCH;
                pc_o          <= fetch_pc;
                mem_req_o     <= 1'b1;
                mem_we_o      <= 1'b0;
                mem_addr_o    <= fetch_pc;
                wait_cnt_q    <= 32'd0;
                retire_o      <= 1'b1;
                retired_cnt_o <= retired_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - directed and randomized bench for multicycle_datapath
module tb_multicycle_datapath;

    localparam logic [3:0] A_AND = 4'b0000, A_OR  = 4'b0001, A_ADD = 4'b0010, A_XOR = 4'b0011;
    localparam logic [3:0] A_SLL = 4'b0100, A_SRL = 4'b0101, A_SUB = 4'b0110, A_SLT = 4'b0111;
    localparam logic [3:0] A_SRA = 4'b1000, A_NOR = 4'b1100;

    logic        clk, rst_i;
    logic        mem_req_o, mem_we_o, mem_ready_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_to_reg_i, mem_write_i, branch_i, branch_ne_i, reg_dst_i, reg_write_i;
    logic [2:0]  jump_i;
    logic [3:0]  alu_control_i;
    logic [1:0]  alu_src_i;
    logic [31:0] instr_o, pc_o;
    logic [2:0]  state_o;
    logic        retire_o, err_o;
    logic [31:0] retired_cnt_o;

    multicycle_datapath #(.RESET_PC(32'h0), .STALL_LIMIT(8), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .mem_to_reg_i(mem_to_reg_i), .mem_write_i(mem_write_i), .branch_i(branch_i),
        .branch_ne_i(branch_ne_i), .jump_i(jump_i), .alu_control_i(alu_control_i),
        .alu_src_i(alu_src_i), .reg_dst_i(reg_dst_i), .reg_write_i(reg_write_i),
        .instr_o(instr_o), .pc_o(pc_o), .state_o(state_o), .retire_o(retire_o),
        .retired_cnt_o(retired_cnt_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External decoder
    always_comb begin
        mem_to_reg_i = 0; mem_write_i = 0; branch_i = 0; branch_ne_i = 0; jump_i = 3'b000;
        alu_control_i = A_ADD; alu_src_i = 2'b00; reg_dst_i = 0; reg_write_i = 0;
        case (instr_o[31:26])
            6'h00: begin
                reg_dst_i = 1; reg_write_i = 1;
                case (instr_o[5:0])
                    6'h00: begin alu_control_i = A_SLL; alu_src_i = 2'b10; end
                    6'h02: begin alu_control_i = A_SRL; alu_src_i = 2'b10; end
                    6'h03: begin alu_control_i = A_SRA; alu_src_i = 2'b10; end
                    6'h08: begin reg_write_i = 0; jump_i = 3'b010; end
                    6'h20, 6'h21: alu_control_i = A_ADD;
                    6'h22: alu_control_i = A_SUB;
                    6'h24: alu_control_i = A_AND;
                    6'h25: alu_control_i = A_OR;
                    6'h26: alu_control_i = A_XOR;
                    6'h27: alu_control_i = A_NOR;
                    6'h2A: alu_control_i = A_SLT;
                    default: reg_write_i = 0;
                endcase
            end
            6'h02: jump_i = 3'b001;
            6'h03: jump_i = 3'b101;
            6'h04: begin branch_i = 1; alu_control_i = A_SUB; end
            6'h05: begin branch_i = 1; branch_ne_i = 1; alu_control_i = A_SUB; end
            6'h08, 6'h09: begin alu_src_i = 2'b01; reg_write_i = 1; end
            6'h0A: begin alu_control_i = A_SLT; alu_src_i = 2'b01; reg_write_i = 1; end
            6'h23: begin alu_src_i = 2'b01; mem_to_reg_i = 1; reg_write_i = 1; end
            6'h2B: begin alu_src_i = 2'b01; mem_write_i = 1; end
            default: ;
        endcase
    end

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] ref_regs [0:31];
    logic [31:0] ref_pc, ref_cnt;
    logic [31:0] m_fetch_pc, m_addr, m_wdata;
    int          m_lat;
    bit          m_has_mem, m_we;
    int          n_pass = 0, n_total = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction
    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    endtask
    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[11:2]] = w; ref_mem[addr[11:2]] = w;
    endtask

    task automatic do_reset();
        int n;
        rst_i = 1; mem_ready_i = 0;
        @(negedge clk); @(negedge clk);
        rst_i = 0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        ref_pc = 32'd0; ref_cnt = 32'd0;
        n = 0;
        while (!mem_req_o && n < 5) begin @(negedge clk); n++; end
        chk("launch_req", mem_req_o, 1);
    endtask

    // Architectural (ISA-level) reference: executes the instruction at ref_pc.
    task automatic model_step();
        logic [31:0] ins, a, b, simm, npc, nxt, res;
        logic [4:0]  rs, rt, rd, sh, wr_r;
        logic [5:0]  op, fn;
        bit          wr_en;
        ins = ref_mem[ref_pc[11:2]];
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6]; fn = ins[5:0];
        simm = {{16{ins[15]}}, ins[15:0]};
        a = ref_regs[rs]; b = ref_regs[rt];
        m_fetch_pc = ref_pc; npc = ref_pc + 4; nxt = npc;
        m_lat = 4; m_has_mem = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        wr_en = 0; wr_r = rt; res = 0;
        case (op)
            6'h00: begin
                wr_en = 1; wr_r = rd;
                case (fn)
                    6'h00: res = b << sh;
                    6'h02: res = b >> sh;
                    6'h03: res = 32'($signed(b) >>> sh);
                    6'h08: begin wr_en = 0; nxt = a; m_lat = 3; end
                    6'h20, 6'h21: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = {31'd0, $signed(a) < $signed(b)};
                    default: wr_en = 0;
                endcase
            end
            6'h02: begin nxt = {npc[31:28], ins[25:0], 2'b00}; m_lat = 3; end
            6'h03: begin nxt = {npc[31:28], ins[25:0], 2'b00}; m_lat = 3; wr_en = 1; wr_r = 5'd31; res = npc; end
            6'h04: begin m_lat = 3; if (a == b) nxt = npc + (simm << 2); end
            6'h05: begin m_lat = 3; if (a != b) nxt = npc + (simm << 2); end
            6'h08, 6'h09: begin wr_en = 1; res = a + simm; end
            6'h0A: begin wr_en = 1; res = {31'd0, $signed(a) < $signed(simm)}; end
            6'h23: begin m_lat = 5; m_has_mem = 1; m_addr = a + simm; wr_en = 1; res = ref_mem[m_addr[11:2]]; end
            6'h2B: begin m_has_mem = 1; m_we = 1; m_addr = a + simm; m_wdata = b; ref_mem[m_addr[11:2]] = b; end
            default: ;
        endcase
        if (wr_en && wr_r != 5'd0) ref_regs[wr_r] = res;
        ref_pc = nxt; ref_cnt++;
    endtask

    // Runs one instruction from the cycle its fetch request is visible until its retire pulse.
    task automatic run_instr(input int wf, input int wm);
        int cyc, wleft, nreq;
        bit prev_req, done;
        logic [64:0] rec;
        model_step();
        chk("fetch_state", state_o, 0);
        chk("fetch_req", mem_req_o, 1);
        chk("fetch_addr", mem_addr_o, m_fetch_pc);
        chk("fetch_we", mem_we_o, 0);
        chk("pc_o", pc_o, m_fetch_pc);
        cyc = 0; nreq = 0; prev_req = 0; done = 0; wleft = 0; rec = '0;
        while (!done) begin
            if (cyc > 0 && retire_o) begin
                chk("latency", cyc, m_lat + wf + (m_has_mem ? wm : 0));
                chk("req_count", nreq, 1 + int'(m_has_mem));
                chk("retired_cnt", retired_cnt_o, ref_cnt);
                done = 1;
            end else if (cyc > 60) begin
                chk("retire_timeout", cyc, 0);
                done = 1;
            end else begin
                if (mem_req_o) begin
                    if (!prev_req) begin
                        nreq++;
                        rec = {mem_addr_o, mem_we_o, mem_wdata_o};
                        wleft = (nreq == 1) ? wf : wm;
                        if (nreq == 2) begin
                            chk("data_addr", mem_addr_o, m_addr);
                            chk("data_we", mem_we_o, m_we);
                            if (m_we) chk("data_wdata", mem_wdata_o, m_wdata);
                        end
                    end else begin
                        chk("req_stable", {mem_addr_o, mem_we_o, mem_wdata_o}, rec);
                    end
                    if (wleft > 0) begin
                        mem_ready_i = 0; mem_rdata_i = $urandom; wleft--;
                    end else begin
                        mem_ready_i = 1; mem_rdata_i = mem[mem_addr_o[11:2]];
                        if (mem_we_o) mem[mem_addr_o[11:2]] = mem_wdata_o;
                    end
                end else begin
                    mem_ready_i = 1'($urandom_range(0, 1));
                    mem_rdata_i = $urandom;
                end
                prev_req = mem_req_o;
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic gen_instr(output logic [31:0] ins);
        logic [4:0] rs, rt, rd;
        logic [5:0] fns [8];
        logic [5:0] shf [3];
        fns = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
        shf = '{6'h00, 6'h02, 6'h03};
        rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(1, 7));
        case ($urandom_range(0, 7))
            0, 1: ins = r_type(rs, rt, rd, 5'd0, fns[$urandom_range(0, 7)]);
            2:    ins = r_type(5'd0, rt, rd, 5'($urandom_range(0, 31)), shf[$urandom_range(0, 2)]);
            3:    ins = i_type(6'h08, rs, rd, 16'($urandom));
            4:    ins = i_type(6'h0A, rs, rd, 16'($urandom));
            5:    ins = i_type(6'h2B, 5'd0, rt, 16'(32'hC00 + 4 * $urandom_range(0, 255)));
            6:    ins = i_type(6'h23, 5'd0, rd, 16'(32'hC00 + 4 * $urandom_range(0, 255)));
            default: ins = i_type($urandom_range(0, 1) ? 6'h04 : 6'h05, rs, rt, 16'($urandom_range(0, 3)));
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        int n;
        rst_i = 1; mem_ready_i = 0; mem_rdata_i = 0;
        clear_mem();

        // Reset in the middle of a fetch
        do_reset();
        @(negedge clk);
        rst_i = 1;
        #1;
        chk("rst_req_drop", mem_req_o, 0);
        chk("rst_state", state_o, 0);
        @(negedge clk);
        rst_i = 0;
        #1;
        chk("rst_pc", pc_o, 0);
        chk("rst_state_rel", state_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_cnt", retired_cnt_o, 0);
        chk("rst_retire", retire_o, 0);

        // addi / sw zero-wait, then lw with three wait states in MEMORY
        clear_mem();
        put(32'h0, i_type(6'h08, 5'd0, 5'd8, 16'd5));
        put(32'h4, i_type(6'h2B, 5'd0, 5'd8, 16'h20));
        put(32'h8, i_type(6'h23, 5'd0, 5'd9, 16'h20));
        put(32'hC, i_type(6'h2B, 5'd0, 5'd9, 16'h24));
        do_reset();
        run_instr(0, 0);
        run_instr(0, 0);
        chk("two_retired", retired_cnt_o, 2);
        chk("store_mem", mem[32'h20 >> 2], 5);
        run_instr(0, 3);
        run_instr(0, 0);
        chk("load_value", mem[32'h24 >> 2], 5);

        // beq taken / bne not taken at 0x10
        for (int k = 0; k < 2; k++) begin
            clear_mem();
            put(32'h10, i_type(k == 0 ? 6'h04 : 6'h05, 5'd0, 5'd0, 16'd3));
            do_reset();
            for (int i = 0; i < 5; i++) run_instr(0, 0);
            chk(k == 0 ? "beq_target" : "bne_target", mem_addr_o, k == 0 ? 32'h20 : 32'h14);
        end

        // jal / jr with link register
        clear_mem();
        put(32'h0,   j_type(6'h02, 26'h10));
        put(32'h40,  j_type(6'h03, 26'h40));
        put(32'h100, i_type(6'h2B, 5'd0, 5'd31, 16'h300));
        put(32'h104, r_type(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
        do_reset();
        run_instr(1, 0);
        run_instr(0, 0);
        chk("jal_target", mem_addr_o, 32'h100);
        run_instr(2, 1);
        chk("link_value", mem[32'h300 >> 2], 32'h44);
        run_instr(0, 0);
        chk("jr_target", mem_addr_o, 32'h44);
        run_instr(0, 0);

        // Fetch stall timeout
        clear_mem();
        do_reset();
        mem_ready_i = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 7) chk("stall_err_early", err_o, 0);
        end
        chk("stall_err", err_o, 1);
        chk("stall_state", state_o, 7);
        chk("stall_req", mem_req_o, 0);
        for (int i = 0; i < 4; i++) begin
            mem_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt_state", state_o, 7);
            chk("halt_retire", retire_o, 0);
            chk("halt_cnt", retired_cnt_o, 0);
        end

        // Randomized program with random wait states
        clear_mem();
        for (int i = 32'hC00 >> 2; i < 1024; i++) begin
            ins = $urandom; mem[i] = ins; ref_mem[i] = ins;
        end
        do_reset();
        chk("rand_err_clear", err_o, 0);
        n = 0;
        while (n < 60) begin
            gen_instr(ins);
            put(ref_pc, ins);
            run_instr($urandom_range(0, 3), $urandom_range(0, 3));
            n++;
        end
        chk("rand_no_err", err_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
